// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, word-addressed instruction memory with a
// program-load port, stall/redirect handling and HLT detection. Produces the
// 64-bit IF_ID register {pc, instruction} consumed by decode.
// Optional fetched-instruction counter enabled by defining FETCH_PERF_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | fetching one word per unstalled cycle, PC advancing
// HALTED | HLT fetched; PC frozen at HLT address, IF_ID fed with NOPs
module fetch_stage #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter logic [31:0] PC_STEP    = 32'h1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_wdata,
  output logic [63:0]       IF_ID,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  localparam logic [31:0] NOP_WORD = 32'h3800_0000;
  localparam logic [5:0]  OPC_HLT  = 6'b001101;

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [63:0] if_id_q, if_id_d;
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] fetch_word;
  logic        fetch_is_hlt;

  // Program-load write port; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (imem_we) imem[imem_addr] <= imem_wdata;
  end

  // Combinational read sees the pre-edge contents, so a same-cycle write
  // to the fetched address returns the old word.
  assign fetch_word   = imem[pc_q[ADDR_W-1:0]];
  assign fetch_is_hlt = (fetch_word[31:26] == OPC_HLT);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // Next-state: redirect always returns to RUN; HLT only counts when fetched.
  always_comb begin
    state_d = state_q;
    if (redirect)                                   state_d = ST_RUN;
    else if (!stall && state_q == ST_RUN && fetch_is_hlt) state_d = ST_HALTED;
  end

  // Halted flag follows the registered state so it rises on the HLT edge.
  always_comb begin
    halted = (state_q == ST_HALTED);
  end

  // PC and IF_ID next values; priority redirect > stall > normal.
  always_comb begin
    pc_d    = pc_q;
    if_id_d = if_id_q;
    if (redirect) begin
      if_id_d = {pc_q, NOP_WORD};
      pc_d    = redirect_pc;
    end else if (!stall) begin
      if (state_q == ST_RUN) begin
        if_id_d = {pc_q, fetch_word};
        if (!fetch_is_hlt) pc_d = pc_q + PC_STEP;
      end else begin
        if_id_d = {pc_q, NOP_WORD};
      end
    end
  end

  // PC and pipeline register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      if_id_q <= {32'h0, NOP_WORD};
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  assign IF_ID = if_id_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        fetch_en;

  // Count every real imem word loaded into IF_ID, saturating at all-ones.
  always_comb begin
    fetch_en      = !redirect && !stall && (state_q == ST_RUN);
    fetch_count_d = fetch_count_q;
    if (fetch_en && fetch_count_q != 32'hFFFF_FFFF) fetch_count_d = fetch_count_q + 32'h1;
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fetch_count_q <= 32'h0;
    else          fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: program load, stall, redirect, halt,
// redirect+stall priority, read-before-write, PC wrap and async reset.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h3800_0000;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [63:0] IF_ID;
  logic        halted;
  logic [31:0] fetch_count;

  int vectors     = 0;
  int miscompares = 0;
  int exp_cnt     = 0;

  fetch_stage dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .IF_ID       (IF_ID),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check IF_ID, halted and fetch_count together.
  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic hl);
    chk({tag, ".if_id"}, IF_ID, {pc, ins});
    chk({tag, ".halted"}, {63'b0, halted}, {63'b0, hl});
    chk({tag, ".count"}, {32'b0, fetch_count}, {32'b0, PERF ? exp_cnt : 0});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    imem_we = 1'b1; imem_addr = a; imem_wdata = d;
    tick();
  endtask

  initial begin
    reset_n = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_we = 1'b0; imem_addr = 8'h0; imem_wdata = 32'h0;
    #2 reset_n = 1'b0;
    #1 chk_all("reset", 32'h0, NOP, 1'b0);

    load(8'd0,   32'h0022_1800);
    load(8'd1,   32'h0400_0000);
    load(8'd2,   32'h3400_0000);
    load(8'd3,   32'h0000_0003);
    load(8'd4,   32'h0000_0004);
    load(8'd5,   32'h0000_0005);
    load(8'd16,  32'h0800_0010);
    load(8'd17,  32'h3400_0000);
    load(8'd255, 32'h0C00_00FF);
    imem_we = 1'b0;
    chk_all("reset_hold", 32'h0, NOP, 1'b0);
    reset_n = 1'b1;

    // first fetch, then stall three cycles
    tick(); exp_cnt = 1; chk_all("fetch0", 32'h0, 32'h0022_1800, 1'b0);
    stall = 1'b1;
    tick(); chk_all("stall1", 32'h0, 32'h0022_1800, 1'b0);
    tick(); chk_all("stall2", 32'h0, 32'h0022_1800, 1'b0);
    tick(); chk_all("stall3", 32'h0, 32'h0022_1800, 1'b0);
    stall = 1'b0;
    tick(); exp_cnt = 2; chk_all("fetch1", 32'h1, 32'h0400_0000, 1'b0);
    tick(); exp_cnt = 3; chk_all("fetch_hlt", 32'h2, 32'h3400_0000, 1'b1);
    tick(); chk_all("halt_nop1", 32'h2, NOP, 1'b1);
    stall = 1'b1;
    tick(); chk_all("halt_stall", 32'h2, NOP, 1'b1);
    stall = 1'b0;
    tick(); chk_all("halt_nop2", 32'h2, NOP, 1'b1);

    // leave HALTED via redirect to 0
    redirect = 1'b1; redirect_pc = 32'h0;
    tick(); chk_all("unhalt_bubble", 32'h2, NOP, 1'b0);
    redirect = 1'b0;
    tick(); exp_cnt = 4; chk_all("refetch0", 32'h0, 32'h0022_1800, 1'b0);

    // redirect while PC=1: wrong-path word squashed
    redirect = 1'b1; redirect_pc = 32'h10;
    tick(); chk_all("redir_bubble", 32'h1, NOP, 1'b0);
    redirect = 1'b0;
    tick(); exp_cnt = 5; chk_all("redir_target", 32'h10, 32'h0800_0010, 1'b0);

    // redirect and stall together: redirect wins
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h10;
    tick(); chk_all("redir_stall_bubble", 32'h11, NOP, 1'b0);
    redirect = 1'b0; stall = 1'b0;
    tick(); exp_cnt = 6; chk_all("redir_stall_target", 32'h10, 32'h0800_0010, 1'b0);
    tick(); exp_cnt = 7; chk_all("hlt17", 32'h11, 32'h3400_0000, 1'b1);

    // redirect to 3, then fetch 3 and 4 with a same-cycle write to 4
    redirect = 1'b1; redirect_pc = 32'h3;
    tick(); chk_all("redir3_bubble", 32'h11, NOP, 1'b0);
    redirect = 1'b0;
    tick(); exp_cnt = 8; chk_all("fetch3", 32'h3, 32'h0000_0003, 1'b0);
    imem_we = 1'b1; imem_addr = 8'd4; imem_wdata = 32'h0000_AAAA;
    tick(); exp_cnt = 9; chk_all("rbw_old", 32'h4, 32'h0000_0004, 1'b0);
    imem_we = 1'b0;

    // async reset mid-fetch (PC=5), no clock edge in between
    #2 reset_n = 1'b0;
    #1 exp_cnt = 0; chk_all("async_reset", 32'h0, NOP, 1'b0);
    #1 reset_n = 1'b1;
    tick(); exp_cnt = 1; chk_all("retained0", 32'h0, 32'h0022_1800, 1'b0);
    tick(); exp_cnt = 2; chk_all("retained1", 32'h1, 32'h0400_0000, 1'b0);

    // word written during the read-before-write cycle is now visible
    redirect = 1'b1; redirect_pc = 32'h4;
    tick(); chk_all("redir4_bubble", 32'h2, NOP, 1'b0);
    redirect = 1'b0;
    tick(); exp_cnt = 3; chk_all("rbw_new", 32'h4, 32'h0000_AAAA, 1'b0);

    // PC beyond IMEM_DEPTH indexes by low bits
    redirect = 1'b1; redirect_pc = 32'h110;
    tick(); chk_all("redir110_bubble", 32'h5, NOP, 1'b0);
    redirect = 1'b0;
    tick(); exp_cnt = 4; chk_all("wrap_index", 32'h110, 32'h0800_0010, 1'b0);

    // PC register wraps at 2^32
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick(); chk_all("redir_max_bubble", 32'h111, NOP, 1'b0);
    redirect = 1'b0;
    tick(); exp_cnt = 5; chk_all("fetch_max", 32'hFFFF_FFFF, 32'h0C00_00FF, 1'b0);
    tick(); exp_cnt = 6; chk_all("pc_wrap", 32'h0, 32'h0022_1800, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
